// File: rtl/hazard_unit.sv
// Stall/flush controller: load-use and HI/LO stalls, branch flush,
// multi-cycle mult/div tracking and a saturating stall counter.
module hazard_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic                   id_muldiv,
  input  logic                   id_reads_hilo,
  input  logic [4:0]             id_ex_rt,
  input  logic                   id_ex_mem_read,
  input  logic                   ex_branch_taken,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   muldiv_busy,
  output logic                   muldiv_done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       load_use;
  logic       hilo_stall;
  logic       stall;
  logic       issue;

  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == id_rs) ||
                (id_uses_rt && (id_ex_rt == id_rt)));
    hilo_stall = (state != IDLE) && (id_reads_hilo || id_muldiv);
    stall = load_use || hilo_stall;
    issue = id_muldiv && !ex_branch_taken && !stall &&
            (state == IDLE);
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign muldiv_busy = !rst && (state != IDLE);
  assign muldiv_done = !rst && (state == DONE);

  // A taken branch is younger than the mult/div, so it never aborts it.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          state_nx = BUSY;
          cnt_nx   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nx = DONE;
        else             cnt_nx   = cnt - 4'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (!pc_write && (stall_cycles != {STALL_CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed plan plus randomized traffic,
// checked every cycle against a cycle-count model.
module tb_hazard_unit;

  localparam int MC = 4;
  localparam int W  = 4;
  localparam int SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   id_rs, id_rt, id_ex_rt;
  logic         id_uses_rt, id_muldiv, id_reads_hilo;
  logic         id_ex_mem_read, ex_branch_taken;
  logic         pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic         muldiv_busy, muldiv_done;
  logic [W-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycles of busy left (incl. done cycle) and stall count
  int m_left = 0;
  int m_cnt  = 0;

  hazard_unit #(.MULDIV_CYCLES(MC), .STALL_CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv(id_muldiv), .id_reads_hilo(id_reads_hilo),
    .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt,
                      input logic md, input logic rh,
                      input logic [4:0] exrt, input logic mr,
                      input logic br);
    bit lu, hs, busy, stl;
    int e_pc, e_ifw, e_fl, e_bub;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_muldiv = md; id_reads_hilo = rh; id_ex_rt = exrt;
    id_ex_mem_read = mr; ex_branch_taken = br;
    @(negedge clk);
    if (r) begin
      m_left = 0;
      m_cnt  = 0;
    end
    busy = (m_left > 0);
    lu = mr && exrt != 0 && (exrt == rs || (urt && exrt == rt));
    hs = busy && (rh || md);
    stl = 1'b0;
    if (r) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
    end else if (br) begin
      e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
    end else if (lu || hs) begin
      e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
      stl = 1'b1;
    end else begin
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
    end
    chk("pc_write", int'(pc_write), e_pc);
    chk("if_id_write", int'(if_id_write), e_ifw);
    chk("if_id_flush", int'(if_id_flush), e_fl);
    chk("id_ex_bubble", int'(id_ex_bubble), e_bub);
    chk("muldiv_busy", int'(muldiv_busy), (!r && m_left > 0) ? 1 : 0);
    chk("muldiv_done", int'(muldiv_done), (!r && m_left == 1) ? 1 : 0);
    chk("stall_cycles", int'(stall_cycles), m_cnt);
    if (!r) begin
      if (e_pc == 0 && m_cnt < SAT) m_cnt = m_cnt + 1;
      if (m_left > 0)
        m_left = m_left - 1;
      else if (md && !br && !stl)
        m_left = MC + 1;
    end
  endtask

  task automatic idle_step();
    step(0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0;
    id_muldiv = 0; id_reads_hilo = 0; id_ex_rt = '0;
    id_ex_mem_read = 0; ex_branch_taken = 0;

    // reset state
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_flush", int'(if_id_flush), 1);
    chk("rst_stall_cnt", int'(stall_cycles), 0);
    idle_step();
    chk("post_rst_pc", int'(pc_write), 1);

    // load-use on rs
    step(0, 5'd8, 5'd3, 1, 0, 0, 5'd8, 1, 0);
    chk("lu_pc", int'(pc_write), 0);
    chk("lu_bubble", int'(id_ex_bubble), 1);
    step(0, 5'd8, 5'd3, 1, 0, 0, 5'd8, 0, 0);
    chk("lu_after_pc", int'(pc_write), 1);
    chk("lu_cnt", int'(stall_cycles), 1);

    // filtering
    step(0, 5'd4, 5'd8, 0, 0, 0, 5'd8, 1, 0);
    chk("rt_unused_pc", int'(pc_write), 1);
    step(0, 5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 0);
    chk("rt_zero_pc", int'(pc_write), 1);

    // mult then mfhi waiting in ID
    step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0);
    chk("issue_pc", int'(pc_write), 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 5'd1, 5'd2, 0, 0, 1, 5'd0, 0, 0);
      chk("md_busy", int'(muldiv_busy), 1);
      chk("md_pc", int'(pc_write), 0);
      chk("md_done", int'(muldiv_done), (i == 5) ? 1 : 0);
    end
    step(0, 5'd1, 5'd2, 0, 0, 1, 5'd0, 0, 0);
    chk("md_release_pc", int'(pc_write), 1);
    chk("md_idle", int'(muldiv_busy), 0);
    chk("md_cnt", int'(stall_cycles), 6);

    // flush beats load-use and issue
    step(0, 5'd8, 5'd3, 1, 1, 0, 5'd8, 1, 1);
    chk("fl_flush", int'(if_id_flush), 1);
    chk("fl_pc", int'(pc_write), 1);
    idle_step();
    chk("fl_no_issue", int'(muldiv_busy), 0);
    chk("fl_cnt", int'(stall_cycles), 6);

    // reset in the middle of a mult/div
    step(0, 5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0);
    idle_step();
    step(1, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0);
    chk("mr_busy", int'(muldiv_busy), 0);
    chk("mr_flush", int'(if_id_flush), 1);
    chk("mr_cnt", int'(stall_cycles), 0);
    for (int i = 0; i < 7; i++) begin
      idle_step();
      chk("mr_no_done", int'(muldiv_done), 0);
    end

    // saturation
    for (int i = 0; i < 20; i++)
      step(0, 5'd9, 5'd3, 0, 0, 0, 5'd9, 1, 0);
    idle_step();
    chk("sat_cnt", int'(stall_cycles), 15);

    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rs, rt, exrt;
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      exrt = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0),
           rs, rt, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           exrt, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall/flush controller for the five-stage pipeline; the complement to the forwarding path: it handles the hazards bypassing cannot resolve. It detects load-use hazards, tracks the multi-cycle mult/div unit via a small FSM, and applies taken-branch flushes. It drives PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MULDIV_CYCLES, 4, execute latency of mult/div in cycles (legal range 1..15)
- STALL_CNT_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- id_ex_rt  in  5  destination (rt) of instruction in EX
- id_ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID to nop
- id_ex_bubble  out  1  load nop into ID/EX
- muldiv_busy  out  1  FSM in BUSY or DONE
- muldiv_done  out  1  one-cycle pulse: HI/LO written this cycle
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0

## Operation
- Control outputs are combinational from inputs and state. Priority: flush > load-use > hilo stall > normal.
- Flush: ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. This overrides any stall. The ID instruction is discarded and is not issued.
- Load-use stall: id_ex_mem_read=1 and id_ex_rt!=0 and (id_ex_rt==id_rs or (id_uses_rt and id_ex_rt==id_rt)).
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - Lasts exactly one cycle, because the bubble clears the load condition.
- Hilo stall: muldiv_busy=1 and (id_reads_hilo or id_muldiv). Outputs are the same as for a load-use stall.
- Normal: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- Issue: id_muldiv=1 in a cycle that is not a flush or stall, with state IDLE.
- FSM states:
  - IDLE: on issue, load cnt=MULDIV_CYCLES-1 and go to BUSY.
  - BUSY: if cnt==0, go to DONE; otherwise cnt-=1.
  - DONE: muldiv_done=1 for one cycle, then go to IDLE.
  - A branch flush never aborts BUSY or DONE, because the mult/div is older than the branch.
- muldiv_busy = (state!=IDLE). cnt width is 4 bits.
- stall_cycles increments on every cycle with pc_write=0 and not in reset. It saturates at all-ones and does not wrap.

## Timing
- Reset (async, while rst=1): state=IDLE, cnt=0, stall_cycles=0.
  - Outputs forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, muldiv_busy=0, muldiv_done=0.
  - After rst deasserts, outputs follow normal rules from the next evaluation.
- Reset mid-BUSY returns the FSM to IDLE immediately. No muldiv_done pulse is produced.
- Mult/div latency, with issue in cycle T:
  - BUSY during T+1..T+MULDIV_CYCLES.
  - DONE (muldiv_done=1) in T+MULDIV_CYCLES+1.
  - A waiting mfhi/mflo leaves ID in T+MULDIV_CYCLES+2.
- A back-to-back mult/div in ID stalls through DONE and issues in the first IDLE cycle.
- Simultaneous flush and load-use: flush wins, pc_write=1, stall_cycles does not increment.
- id_muldiv together with ex_branch_taken in the same cycle is not an issue; the FSM stays IDLE.
- Load-use with id_ex_rt=0 never stalls.

## Test plan
- Load-use on rs: id_ex_mem_read=1, id_ex_rt=8, id_rs=8.
  - Required: one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, and stall_cycles goes 0->1.
  - Then inputs drop mem_read -> normal.
- Load-use filtering:
  - id_ex_rt=8, id_rt=8, id_uses_rt=0 -> no stall.
  - id_ex_rt=0, id_rs=0 -> no stall.
- Mult/div with MULDIV_CYCLES=4: issue at T, mfhi in ID from T+1.
  - Required: muldiv_busy high for T+1..T+5, muldiv_done high only in T+5, pc_write=0 for T+1..T+5, and pc_write=1 in T+6.
- Flush priority: ex_branch_taken=1 together with a load-use condition and id_muldiv=1.
  - Required: if_id_flush=1, id_ex_bubble=1, pc_write=1, FSM stays IDLE, stall_cycles unchanged.
- Reset mid-operation: assert rst at T+2 of a mult/div.
  - Required: immediately muldiv_busy=0, pc_write=0, if_id_flush=1, stall_cycles=0, and no muldiv_done afterwards.
- Saturation: STALL_CNT_W=4 with 20 consecutive stall cycles.
  - Required: stall_cycles reaches 15 and holds at 15.
